maze_run_sequencer: RTL and testbench

- Top-level run controller for the video-stream maze solver.
- Sequences the solver through its phases: bypass, calibration (start/end pose search), stepping, and result display.
- Issues one-cycle step/clear strobes to the pose-update datapath, aligned to frame boundaries.
- Sits between the video timing inputs and the solver/overlay logic; it owns all per-frame scheduling decisions.

---
 rtl/maze_pkg.sv | 27 ++
 rtl/frame_edge_detect.sv | 41 ++++
 rtl/maze_run_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_maze_run_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze solver: FSM state codes, run-mode codes
// and common datapath widths.
package maze_pkg;

  localparam int unsigned STATE_W         = 3;
  localparam int unsigned MODE_W          = 2;
  localparam int unsigned ROW_W           = 10;
  localparam int unsigned CNT_W           = 10;
  localparam int unsigned HOLD_W          = 8;
  localparam int unsigned END_ROW_DEFAULT = 270;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CALIB = 3'd1,
    ST_RUN   = 3'd2,
    ST_WIN   = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_BYPASS = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_SINGLE = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_e;

endpackage

// File: rtl/frame_edge_detect.sv
// Frame boundary detector for the video timing stream.
// Ports: clk, rst_n (async active-low), frame_valid (active-frame level);
//        fstart_c / fend_c (raw rising/falling edges, combinational),
//        fend_valid_c (falling edge of a frame whose start was observed).
module frame_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_valid,
  output logic fstart_c,
  output logic fend_c,
  output logic fend_valid_c
);

  logic frame_valid_z;
  logic in_frame;
  logic armed;

  assign fstart_c     = ~frame_valid_z & frame_valid;
  assign fend_c       = frame_valid_z & ~frame_valid;
  assign fend_valid_c = fend_c & in_frame;

  // armed is set once frame_valid has been seen low after reset: the zero
  // reset value of frame_valid_z would otherwise fake a start edge when
  // reset releases in the middle of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid_z <= 1'b0;
      in_frame      <= 1'b0;
      armed         <= 1'b0;
    end else begin
      frame_valid_z <= frame_valid;
      armed         <= armed | ~frame_valid;
      if (fstart_c && armed) begin
        in_frame <= 1'b1;
      end else if (fend_c) begin
        in_frame <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/maze_run_sequencer.sv
// Run controller for the video-stream maze solver. Steps the solver through
// IDLE -> CALIB -> RUN -> WIN/FAIL, deciding everything once per completed
// frame and issuing one-cycle step/clear strobes one clock after the frame end.
// Ports: clk, reset (async active-low), mode, video_frame_valid, step_req,
//        cal_ok, pose_row, pose_lost, dead_end;
//        state, calib_en, run_en, step_pulse, solver_clear, show_win,
//        show_fail, step_cnt, frame_cnt (all registered).
module maze_run_sequencer
  import maze_pkg::*;
#(
  parameter int unsigned STEP_DIV_LOG2 = 2,
  parameter int unsigned HOLD_FRAMES   = 250,
  parameter int unsigned CALIB_MAX     = 8,
  parameter int unsigned MAX_STEPS     = 1000,
  parameter int unsigned END_ROW       = END_ROW_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MODE_W-1:0]  mode,
  input  logic               video_frame_valid,
  input  logic               step_req,
  input  logic               cal_ok,
  input  logic [ROW_W-1:0]   pose_row,
  input  logic               pose_lost,
  input  logic               dead_end,
  output logic [STATE_W-1:0] state,
  output logic               calib_en,
  output logic               run_en,
  output logic               step_pulse,
  output logic               solver_clear,
  output logic               show_win,
  output logic               show_fail,
  output logic [CNT_W-1:0]   step_cnt,
  output logic [CNT_W-1:0]   frame_cnt
);

  localparam int unsigned CAL_W = $clog2(CALIB_MAX + 1);
  localparam logic [CNT_W-1:0] STEP_MASK = CNT_W'((1 << STEP_DIV_LOG2) - 1);

  state_e             state_q, state_d;
  logic [CAL_W-1:0]   cal_q, cal_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   step_cnt_d, frame_cnt_d;
  logic               lost_f, dead_f, req_f;
  logic               lost_d, dead_d, req_d;
  logic               lost_now, dead_now, req_now;
  logic               do_step, do_clear;
  logic               step_pulse_d, solver_clear_d;
  logic               calib_en_d, run_en_d, show_win_d, show_fail_d;
  logic               fstart, fend, fend_valid;
  logic               unused_edges;

  frame_edge_detect u_edge (
    .clk          (clk),
    .rst_n        (reset),
    .frame_valid  (video_frame_valid),
    .fstart_c     (fstart),
    .fend_c       (fend),
    .fend_valid_c (fend_valid)
  );

  assign unused_edges = &{1'b0, fstart, fend};
  assign state        = state_q;

  // Events in the fend cycle itself still belong to the ending frame.
  assign lost_now = lost_f | pose_lost;
  assign dead_now = dead_f | dead_end;
  assign req_now  = req_f | step_req;

  // State and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cal_q        <= '0;
      hold_q       <= '0;
      step_cnt     <= '0;
      frame_cnt    <= '0;
      lost_f       <= 1'b0;
      dead_f       <= 1'b0;
      req_f        <= 1'b0;
      step_pulse   <= 1'b0;
      solver_clear <= 1'b0;
      calib_en     <= 1'b0;
      run_en       <= 1'b0;
      show_win     <= 1'b0;
      show_fail    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cal_q        <= cal_d;
      hold_q       <= hold_d;
      step_cnt     <= step_cnt_d;
      frame_cnt    <= frame_cnt_d;
      lost_f       <= lost_d;
      dead_f       <= dead_d;
      req_f        <= req_d;
      step_pulse   <= step_pulse_d;
      solver_clear <= solver_clear_d;
      calib_en     <= calib_en_d;
      run_en       <= run_en_d;
      show_win     <= show_win_d;
      show_fail    <= show_fail_d;
    end
  end

  // Per-frame scheduling decision, evaluated only on a qualified frame end.
  always_comb begin
    state_d     = state_q;
    cal_d       = cal_q;
    hold_d      = hold_q;
    step_cnt_d  = step_cnt;
    frame_cnt_d = frame_cnt;
    do_step     = 1'b0;
    do_clear    = 1'b0;
    if (fend_valid) begin
      frame_cnt_d = frame_cnt + CNT_W'(1);
      if (mode == MODE_BYPASS) begin
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_d    = ST_CALIB;
            do_clear   = 1'b1;
            cal_d      = '0;
            step_cnt_d = '0;
          end
          ST_CALIB: begin
            if (cal_ok) begin
              state_d    = ST_RUN;
              step_cnt_d = '0;
            end else begin
              cal_d = cal_q + CAL_W'(1);
              if (cal_d == CAL_W'(CALIB_MAX)) begin
                state_d = ST_FAIL;
                hold_d  = '0;
              end
            end
          end
          ST_RUN: begin
            if (lost_now) begin
              state_d  = ST_CALIB;
              do_clear = 1'b1;
              cal_d    = '0;
            end else if (pose_row > ROW_W'(END_ROW)) begin
              state_d = ST_WIN;
              hold_d  = '0;
            end else if (dead_now || step_cnt == CNT_W'(MAX_STEPS)) begin
              state_d = ST_FAIL;
              hold_d  = '0;
            end else begin
              // Auto mode tests the frame counter before this frame's increment.
              unique case (mode)
                MODE_AUTO:   do_step = ((frame_cnt & STEP_MASK) == '0);
                MODE_SINGLE: do_step = req_now;
                default:     do_step = 1'b0;
              endcase
              if (do_step && step_cnt != '1) begin
                step_cnt_d = step_cnt + CNT_W'(1);
              end
            end
          end
          ST_WIN, ST_FAIL: begin
            hold_d = hold_q + HOLD_W'(1);
            if (hold_d == HOLD_W'(HOLD_FRAMES)) begin
              state_d  = ST_CALIB;
              do_clear = 1'b1;
              hold_d   = '0;
              cal_d    = '0;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Strobes, status flags and sticky event latches for the next cycle.
  always_comb begin
    step_pulse_d   = do_step;
    solver_clear_d = do_clear;
    calib_en_d     = (state_d == ST_CALIB);
    run_en_d       = (state_d == ST_RUN);
    show_win_d     = (state_d == ST_WIN);
    show_fail_d    = (state_d == ST_FAIL);
    lost_d         = fend_valid ? 1'b0 : lost_now;
    dead_d         = fend_valid ? 1'b0 : dead_now;
    req_d          = (fend_valid || (state_q == ST_RUN && state_d != ST_RUN)) ? 1'b0 : req_now;
  end

endmodule

// File: tb/tb_maze_run_sequencer.sv
// Randomized self-checking bench for maze_run_sequencer with a frame-level
// reference model of the run controller.
module tb_maze_run_sequencer;

  localparam int S_IDLE = 0, S_CALIB = 1, S_RUN = 2, S_WIN = 3, S_FAIL = 4;
  localparam int AT_END = 99;
  localparam int NONE   = -1;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       video_frame_valid;
  logic       step_req, cal_ok, pose_lost, dead_end;
  logic [9:0] pose_row;
  logic [2:0] state;
  logic       calib_en, run_en, step_pulse, solver_clear, show_win, show_fail;
  logic [9:0] step_cnt, frame_cnt;

  maze_run_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .mode              (mode),
    .video_frame_valid (video_frame_valid),
    .step_req          (step_req),
    .cal_ok            (cal_ok),
    .pose_row          (pose_row),
    .pose_lost         (pose_lost),
    .dead_end          (dead_end),
    .state             (state),
    .calib_en          (calib_en),
    .run_en            (run_en),
    .step_pulse        (step_pulse),
    .solver_clear      (solver_clear),
    .show_win          (show_win),
    .show_fail         (show_fail),
    .step_cnt          (step_cnt),
    .frame_cnt         (frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe monitor: cumulative high-cycle counts.
  int n_step = 0, n_clr = 0, n_both = 0;
  always @(posedge clk) begin
    n_step += int'(step_pulse);
    n_clr  += int'(solver_clear);
    n_both += int'(step_pulse & solver_clear);
  end

  // Reference model: one decision per completed frame.
  int m_state, m_cal, m_hold, m_step, m_frame;
  bit e_step, e_clr;

  task automatic model_reset();
    m_state = S_IDLE; m_cal = 0; m_hold = 0; m_step = 0; m_frame = 0;
  endtask

  task automatic model_fend(input int md, input bit cal, input int row,
                            input bit lost, input bit dead, input bit req);
    int pre;
    bit go;
    e_step = 0; e_clr = 0;
    pre = m_frame;
    m_frame = (m_frame + 1) % 1024;
    if (md == 0) begin
      m_state = S_IDLE;
    end else if (m_state == S_IDLE) begin
      m_state = S_CALIB; e_clr = 1; m_cal = 0; m_step = 0;
    end else if (m_state == S_CALIB) begin
      if (cal) begin
        m_state = S_RUN; m_step = 0;
      end else begin
        m_cal++;
        if (m_cal == 8) begin m_state = S_FAIL; m_hold = 0; end
      end
    end else if (m_state == S_RUN) begin
      if (lost) begin
        m_state = S_CALIB; e_clr = 1; m_cal = 0;
      end else if (row > 270) begin
        m_state = S_WIN; m_hold = 0;
      end else if (dead || m_step == 1000) begin
        m_state = S_FAIL; m_hold = 0;
      end else begin
        go = (md == 1) ? (pre % 4 == 0) : (md == 2) ? req : 1'b0;
        if (go) begin
          e_step = 1;
          if (m_step < 1023) m_step++;
        end
      end
    end else begin
      m_hold++;
      if (m_hold == 250) begin m_state = S_CALIB; e_clr = 1; m_hold = 0; m_cal = 0; end
    end
  endtask

  int mid_state;

  // One full frame: mode md0 switching to md1 mid-frame; event positions are
  // active-cycle indices, AT_END (clamped) meaning the fend cycle, NONE absent.
  task automatic do_frame(input int md0, input int md1, input bit cal, input int row,
                          input int lost_at, input int dead_at, input int req_at, input int req2_at);
    int act, sp0, sc0, gap, la, da, ra, rb;
    act = $urandom_range(5, 2);
    gap = $urandom_range(3, 1);
    la = (lost_at > act) ? act : lost_at;
    da = (dead_at > act) ? act : dead_at;
    ra = (req_at  > act) ? act : req_at;
    rb = (req2_at > act) ? act : req2_at;
    sp0 = n_step; sc0 = n_clr;
    mode = 2'(md0); cal_ok = cal; pose_row = 10'(row);
    for (int c = 0; c <= act; c++) begin
      video_frame_valid = (c < act);
      if (c == act / 2) mode = 2'(md1);
      pose_lost = (c == la);
      dead_end  = (c == da);
      step_req  = (c == ra) || (c == rb);
      @(posedge clk); #1;
      if (c == act - 1) mid_state = int'(state);
    end
    pose_lost = 0; dead_end = 0; step_req = 0;
    model_fend(md1, cal, row, la >= 0, da >= 0, (ra >= 0) || (rb >= 0));
    chk("state", 32'(state), 32'(m_state));
    chk("step_pulse", 32'(step_pulse), 32'(e_step));
    chk("solver_clear", 32'(solver_clear), 32'(e_clr));
    chk("step_cnt", 32'(step_cnt), 32'(m_step));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
    chk("flags", 32'({calib_en, run_en, show_win, show_fail}),
        32'({m_state == S_CALIB, m_state == S_RUN, m_state == S_WIN, m_state == S_FAIL}));
    repeat (gap) begin @(posedge clk); #1; end
    chk("step_count_frame", 32'(n_step - sp0), 32'(e_step));
    chk("clear_count_frame", 32'(n_clr - sc0), 32'(e_clr));
  endtask

  initial begin
    int s0, guard, md0, md1;
    reset = 0; mode = 2'b01; video_frame_valid = 1; step_req = 0; cal_ok = 0;
    pose_row = 0; pose_lost = 0; dead_end = 0;
    #1;
    chk("reset_state", 32'(state), 0);
    chk("reset_outputs", 32'({calib_en, run_en, step_pulse, solver_clear, show_win, show_fail}), 0);
    chk("reset_counts", 32'({step_cnt, frame_cnt}), 0);
    model_reset();

    // Reset released mid-frame: the partial frame's end is ignored.
    repeat (2) @(posedge clk);
    #1 reset = 1;
    repeat (2) begin @(posedge clk); #1; end
    video_frame_valid = 0;
    @(posedge clk); #1;
    chk("partial_state", 32'(state), 0);
    chk("partial_frame_cnt", 32'(frame_cnt), 0);
    chk("partial_clear", 32'(solver_clear), 0);
    repeat (2) begin @(posedge clk); #1; end

    // IDLE -> CALIB, then calibration timeout and the FAIL hold period.
    do_frame(1, 1, 0, 0, NONE, NONE, NONE, NONE);
    for (int i = 0; i < 8; i++) do_frame(1, 1, 0, 0, NONE, NONE, NONE, NONE);
    chk("calib_timeout", 32'(state), S_FAIL);
    for (int i = 0; i < 250; i++) do_frame(1, 1, 0, 0, NONE, NONE, NONE, NONE);
    chk("hold_done", 32'(state), S_CALIB);

    // Auto stepping: 12 frames give exactly 3 steps.
    do_frame(1, 1, 1, 0, NONE, NONE, NONE, NONE);
    s0 = n_step;
    for (int i = 0; i < 12; i++) do_frame(1, 1, 0, 100, NONE, NONE, NONE, NONE);
    chk("auto_steps_12", 32'(n_step - s0), 3);
    chk("auto_step_cnt", 32'(step_cnt), 3);

    // Single step: two requests in one frame, then none.
    do_frame(2, 2, 0, 100, NONE, NONE, 1, AT_END);
    do_frame(2, 2, 0, 100, NONE, NONE, NONE, NONE);

    // Lost beats dead end; then recalibrate and reach the goal row.
    do_frame(2, 2, 0, 100, 1, 1, NONE, NONE);
    do_frame(2, 2, 1, 100, NONE, NONE, NONE, NONE);
    do_frame(2, 2, 0, 271, NONE, NONE, NONE, NONE);
    chk("win_state", 32'(state), S_WIN);

    // Bypass requested mid-frame only acts at the frame end.
    for (int i = 0; i < 250; i++) do_frame(1, 1, 0, 0, NONE, NONE, NONE, NONE);
    do_frame(1, 1, 1, 0, NONE, NONE, NONE, NONE);
    do_frame(1, 0, 0, 0, NONE, NONE, NONE, NONE);
    chk("mid_frame_state", 32'(mid_state), S_RUN);

    // Step budget exhaustion in auto mode.
    do_frame(1, 1, 0, 0, NONE, NONE, NONE, NONE);
    do_frame(1, 1, 1, 0, NONE, NONE, NONE, NONE);
    guard = 0;
    while (m_step < 1000 && guard < 4100) begin
      do_frame(1, 1, 0, 200, NONE, NONE, NONE, NONE);
      guard++;
    end
    chk("budget_reached", 32'(step_cnt), 1000);
    do_frame(1, 1, 0, 200, NONE, NONE, NONE, NONE);
    chk("budget_fail", 32'(state), S_FAIL);

    // Randomized frames.
    for (int i = 0; i < 400; i++) begin
      md0 = $urandom_range(3, 0);
      case ($urandom_range(9, 0))
        0:          md1 = 0;
        1, 2, 3, 4: md1 = 1;
        5, 6, 7:    md1 = 2;
        default:    md1 = 3;
      endcase
      do_frame(md0, md1, 1'($urandom_range(1, 0)),
               ($urandom_range(9, 0) == 0) ? int'($urandom_range(1023, 271)) : int'($urandom_range(270, 0)),
               ($urandom_range(9, 0) == 0) ? int'($urandom_range(7, 0)) : NONE,
               ($urandom_range(9, 0) == 0) ? int'($urandom_range(7, 0)) : NONE,
               ($urandom_range(1, 0) == 0) ? int'($urandom_range(7, 0)) : NONE,
               ($urandom_range(3, 0) == 0) ? AT_END : NONE);
    end

    chk("strobe_overlap", 32'(n_both), 0);

    // Asynchronous reset in the middle of a frame.
    video_frame_valid = 1; mode = 2'b01;
    repeat (2) begin @(posedge clk); #1; end
    reset = 0;
    #1;
    chk("async_reset_state", 32'(state), 0);
    chk("async_reset_flags", 32'({calib_en, run_en, show_win, show_fail, step_pulse, solver_clear}), 0);
    chk("async_reset_cnt", 32'({step_cnt, frame_cnt}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
